// File: rtl/car_lane_renderer.sv
// Car lane renderer: erases the player's car at its old lane and redraws it at
// the new lane, emitting one pixel per cycle for a 160x120 3-bit VGA adapter.
module car_lane_renderer #(
    parameter int unsigned CAR_W      = 8,
    parameter int unsigned CAR_H      = 12,
    parameter int unsigned CAR_Y      = 100,
    parameter int unsigned LANE0_X    = 36,
    parameter int unsigned LANE1_X    = 76,
    parameter int unsigned LANE2_X    = 116,
    parameter logic [2:0]  CAR_COLOUR = 3'b100,
    parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic [1:0] lane_select,
    output logic [8:0] oX,
    output logic [7:0] oY,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       oBusy,
    output logic       oDone
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned X_W   = 9;
    localparam int unsigned Y_W   = 8;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cur_lane_q, cur_lane_d;
    logic [1:0]         tgt_lane_q, tgt_lane_d;
    logic [CNT_W-1:0]   cx_q, cx_d;
    logic [CNT_W-1:0]   cy_q, cy_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [2:0]         colour_q, colour_d;
    logic               plot_q, plot_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Left column of the car for a given lane; lane 3 never reaches here.
    function automatic logic [X_W-1:0] lane_x(input logic [1:0] lane);
        case (lane)
            2'd0:    lane_x = X_W'(LANE0_X);
            2'd2:    lane_x = X_W'(LANE2_X);
            default: lane_x = X_W'(LANE1_X);
        endcase
    endfunction

    logic       last_col;
    logic       last_row;
    logic [1:0] pix_lane;

    // Next-state, counter and pixel output logic.
    always_comb begin
        state_d    = state_q;
        cur_lane_d = cur_lane_q;
        tgt_lane_d = tgt_lane_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        last_col = (cx_q == CNT_W'(CAR_W - 1));
        last_row = (cy_q == CNT_W'(CAR_H - 1));
        pix_lane = (state_q == S_ERASE) ? cur_lane_q : tgt_lane_q;

        case (state_q)
            S_INIT: begin
                tgt_lane_d = 2'd1;
                cx_d       = '0;
                cy_d       = '0;
                state_d    = S_DRAW;
            end
            S_IDLE: begin
                if (lane_select != 2'd3 && lane_select != cur_lane_q) begin
                    tgt_lane_d = lane_select;
                    state_d    = S_ERASE;
                end
            end
            S_ERASE, S_DRAW: begin
                x_d      = lane_x(pix_lane) + X_W'(cx_q);
                y_d      = Y_W'(CAR_Y) + Y_W'(cy_q);
                colour_d = (state_q == S_ERASE) ? BG_COLOUR : CAR_COLOUR;
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                if (!last_col) begin
                    cx_d = cx_q + CNT_W'(1);
                end else begin
                    cx_d = '0;
                    if (!last_row) begin
                        cy_d = cy_q + CNT_W'(1);
                    end else begin
                        cy_d = '0;
                        if (state_q == S_ERASE) begin
                            state_d = S_DRAW;
                        end else begin
                            cur_lane_d = tgt_lane_q;
                            state_d    = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q    <= S_INIT;
            cur_lane_q <= 2'd1;
            tgt_lane_q <= 2'd1;
            cx_q       <= '0;
            cy_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_lane_q <= cur_lane_d;
            tgt_lane_q <= tgt_lane_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = colour_q;
    assign oPlot   = plot_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;

endmodule

// File: tb/tb_car_lane_renderer.sv
// Scoreboard bench for car_lane_renderer: stimulus queues expected pixels and
// done pulses, a negedge monitor pops and compares whatever the DUT emits.
module tb_car_lane_renderer;

    logic       clk;
    logic       iReset;
    logic [1:0] lane_select;
    logic [8:0] oX;
    logic [7:0] oY;
    logic [2:0] oColour;
    logic       oPlot;
    logic       oBusy;
    logic       oDone;

    car_lane_renderer dut (
        .iClock     (clk),
        .iReset     (iReset),
        .lane_select(lane_select),
        .oX         (oX),
        .oY         (oY),
        .oColour    (oColour),
        .oPlot      (oPlot),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gap: required count of idle monitor cycles before this entry, -1 = any
    typedef struct {
        bit is_done;
        int x;
        int y;
        int c;
        int gap;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   idle_run = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue the first n pixels of a row-major scan of the car at column lx.
    task automatic push_rect(input int lx, input int colour, input int first_gap, input int n);
        exp_t e;
        int   k;
        k = 0;
        for (int cy = 0; cy < 12; cy++) begin
            for (int cx = 0; cx < 8; cx++) begin
                if (k < n) begin
                    e.is_done = 1'b0;
                    e.x       = lx + cx;
                    e.y       = 100 + cy;
                    e.c       = colour;
                    e.gap     = (k == 0) ? first_gap : 0;
                    sb_q.push_back(e);
                end
                k++;
            end
        end
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.x       = 0;
        e.y       = 0;
        e.c       = 0;
        e.gap     = 0;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"},      int'(oX),      0);
        check({tag, "_y"},      int'(oY),      0);
        check({tag, "_colour"}, int'(oColour), 0);
        check({tag, "_plot"},   int'(oPlot),   0);
        check({tag, "_busy"},   int'(oBusy),   0);
        check({tag, "_done"},   int'(oDone),   0);
    endtask

    // Monitor: compare every emitted pixel / done pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("busy_vs_plot", int'(oBusy), int'(oPlot));
            if (oPlot || oDone) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", int'({oPlot, oDone}), 0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.gap >= 0) check("gap_cycles", idle_run, e.gap);
                    if (e.is_done) begin
                        check("done_pulse", int'(oDone), 1);
                        check("done_plot",  int'(oPlot), 0);
                    end else begin
                        check("pix_plot",   int'(oPlot),   1);
                        check("pix_x",      int'(oX),      e.x);
                        check("pix_y",      int'(oY),      e.y);
                        check("pix_colour", int'(oColour), e.c);
                    end
                end
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
    end

    initial begin
        iReset      = 1'b1;
        lane_select = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Power-up paint in the centre lane.
        @(negedge clk);
        push_rect(76, 4, -1, 96);
        push_done();
        iReset = 1'b0;
        wait_drain(300);

        // Lane 1 -> 0 with exact start latency.
        @(negedge clk);
        lane_select = 2'd0;
        push_rect(76, 0, -1, 96);
        push_rect(36, 4, 0, 96);
        push_done();
        @(posedge clk);
        #1 check("lat_edge_k_plot", int'(oPlot), 0);
        @(posedge clk);
        #1 check("lat_edge_k1_plot", int'(oPlot), 1);
        check("lat_edge_k1_busy", int'(oBusy), 1);
        wait_drain(400);

        // Illegal lane value is ignored.
        @(negedge clk);
        lane_select = 2'd3;
        repeat (50) begin
            @(negedge clk);
            check("lane3_plot", int'(oPlot), 0);
            check("lane3_busy", int'(oBusy), 0);
        end

        // 0 -> 1, retargeted to 2 mid-draw: second op one idle cycle after done.
        @(negedge clk);
        lane_select = 2'd1;
        push_rect(36, 0, -1, 96);
        push_rect(76, 4, 0, 96);
        push_done();
        push_rect(76, 0, 1, 96);
        push_rect(116, 4, 0, 96);
        push_done();
        repeat (120) @(negedge clk);
        lane_select = 2'd2;
        wait_drain(800);

        // 2 -> 1 to set up the next case.
        @(negedge clk);
        lane_select = 2'd1;
        push_rect(116, 0, -1, 96);
        push_rect(76, 4, 0, 96);
        push_done();
        wait_drain(400);

        // 1 -> 2 with a 0 glitch during the erase: only 1 -> 2 is rendered.
        @(negedge clk);
        lane_select = 2'd2;
        push_rect(76, 0, -1, 96);
        push_rect(116, 4, 0, 96);
        push_done();
        repeat (30) @(negedge clk);
        lane_select = 2'd0;
        repeat (10) @(negedge clk);
        lane_select = 2'd2;
        wait_drain(400);
        repeat (20) @(negedge clk);
        check("settled_busy", int'(oBusy), 0);
        check("settled_plot", int'(oPlot), 0);

        // Reset on erase pixel 40 (2 -> 0), then the centre-lane init paint.
        @(negedge clk);
        lane_select = 2'd0;
        push_rect(116, 0, -1, 40);
        repeat (41) @(negedge clk);
        iReset      = 1'b1;
        lane_select = 2'd1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        check("midreset_sb_empty", sb_q.size(), 0);
        sb_q.delete();
        push_rect(76, 4, 2, 96);
        push_done();
        iReset = 1'b0;
        wait_drain(300);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/car_lane_renderer.md
Name: car_lane_renderer

Overview:
- Drawing stage between the keyboard lane-select register and the VGA adapter.
- Watches the player's lane number. When the lane changes, it erases the car rectangle at the old lane, then draws it at the new lane.
- Outputs one pixel per cycle on x/y/colour/plot, in the form the 160x120, 3-bit-colour vga_adapter consumes.
- After reset it paints the car once in the centre lane.

Parameters:
- CAR_W, 8, car width in pixels (1..32)
- CAR_H, 12, car height in pixels (1..32)
- CAR_Y, 100, top row of car; CAR_Y+CAR_H-1 must be ≤ 119
- LANE0_X, 36, left column of car in lane 0
- LANE1_X, 76, left column of car in lane 1
- LANE2_X, 116, left column of car in lane 2; each LANEn_X+CAR_W-1 must be ≤ 159
- CAR_COLOUR, 3'b100, colour of car pixels
- BG_COLOUR, 3'b000, colour written when erasing

Ports:
- iClock  in  1  system clock (CLOCK_50)
- iReset  in  1  synchronous, active-high reset
- lane_select  in  2  requested lane: 0, 1 or 2; value 3 is illegal
- oX  out  9  pixel x coordinate
- oY  out  8  pixel y coordinate
- oColour  out  3  pixel colour
- oPlot  out  1  write strobe; pixel is valid when high
- oBusy  out  1  high while an erase or draw is in progress
- oDone  out  1  one-cycle pulse when a draw completes

Behaviour:
- All outputs are registered. While iReset is high at an edge: oX=0, oY=0, oColour=0, oPlot=0, oBusy=0, oDone=0, state=INIT, cur_lane=1, counters cx=cy=0.
- States:
  - INIT: one cycle, then go to DRAW with tgt_lane=1. No erase phase.
  - IDLE: sample lane_select each cycle. If it is in {0,1,2} and differs from cur_lane, latch tgt_lane=lane_select and go to ERASE. Otherwise stay. Value 3 is ignored.
  - ERASE: one pixel per cycle at (LANE_X[cur_lane]+cx, CAR_Y+cy), colour BG_COLOUR.
  - DRAW: one pixel per cycle at (LANE_X[tgt_lane]+cx, CAR_Y+cy), colour CAR_COLOUR.
- Scan order is row-major: cx runs 0..CAR_W-1 fastest, then cy runs 0..CAR_H-1. Counters clear when a phase ends.
- ERASE is followed directly by DRAW: no gap cycle, and oPlot stays high.
- Each phase keeps oPlot high for exactly CAR_W*CAR_H consecutive cycles.
- Latency: a lane change first seen in IDLE at edge k puts the first erase pixel on the outputs after edge k+1.
- The edge that issues the last DRAW pixel also sets cur_lane=tgt_lane. The next edge drives oPlot=0, oDone=1 for exactly one cycle, oBusy=0, and state=IDLE.
- oBusy is high from the first output pixel through the last output pixel, and low otherwise.
- When oPlot=0, oX/oY/oColour hold their last values.
- lane_select changes during ERASE/DRAW are not latched mid-operation. The first IDLE cycle re-compares, so only the final value is rendered and intermediate lanes are skipped.
- A lane that returns to cur_lane before the render finishes produces no further operation.
- Reset asserted mid-operation aborts immediately: reset values apply and the sequence restarts from INIT. A partially drawn frame is not cleaned up.
- Arithmetic: oX = LANE_X + cx zero-extended to 9 bits; oY = CAR_Y + cy at 8 bits; no wrap permitted, given the parameter constraints.
- Pixel counters are 5 bits each.

Test Plan:
- Reset, then release → 96 consecutive oPlot cycles, colour 3'b100: first pixel (76,100), last (83,111); then oDone pulse, oBusy=0.
- Idle, lane_select 1→0 → 96 erase pixels (76..83,100..111, colour 000), then 96 draw pixels (36..43,100..111, colour 100) back-to-back; oPlot continuously high for 192 cycles; oDone once.
- lane_select held at 3 for 50 cycles → oPlot stays 0, oBusy stays 0.
- During an erase 1→2, switch lane_select to 0 and back to 2 → completes 1→2 (erase at x 76, draw at x 116). No further operation afterwards, because cur_lane=2.
- During a draw 0→1, switch lane_select to 2 → after oDone, a second erase at x 76 and draw at x 116 start one cycle after IDLE is re-entered.
- Assert iReset for one cycle at pixel 40 of an erase → outputs zero next cycle; the init draw in lane 1 follows (96 pixels at x 76).
